leitor_tabuleiro: RTL

- Scans the 8x8 reed-switch matrix under the chess board and debounces every square.
- Turns piece lift/place sequences into a completed move: origin square, destination square and a one-cycle jogou pulse.
- Sits directly upstream of the game datapath. jogadaLinha, jogadaColuna and jogou drive its move register and jogada edge detector.
- Supports simple moves, captures and cancelled moves. Illegal multi-lift sequences are flagged.

---
 rtl/leitor_tabuleiro.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/leitor_tabuleiro.sv
// Chess board reader: scans the 8x8 reed-switch matrix, debounces every square
// and turns lift/place events into completed moves for the game datapath.
module leitor_tabuleiro #(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] colunas,
    output logic [7:0] linhas_varredura,
    output logic [3:0] jogadaLinha,
    output logic [3:0] jogadaColuna,
    output logic [3:0] origemLinha,
    output logic [3:0] origemColuna,
    output logic       jogou,
    output logic       erroMulti,
    output logic [2:0] db_estado
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE);

    typedef enum logic [2:0] {
        CALIBRA   = 3'd0,
        OCIOSO    = 3'd1,
        LEVANTADA = 3'd2,
        CAPTURA   = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    logic [2:0]             row_q, row_d;
    logic [SW-1:0]          set_q, set_d;
    logic [63:0]            acc_q, acc_d;
    logic [63:0][CW-1:0]    dcnt_q, dcnt_d;
    logic [63:0]            snap_q, snap_d;
    estado_t                state_q, state_d;
    logic [5:0]             org_q, org_d;
    logic [5:0]             cap_q, cap_d;
    logic [CW-1:0]          scan_q, scan_d;
    logic [5:0]             dest_q, dest_d;
    logic [5:0]             orig_q, orig_d;
    logic                   jogou_q, jogou_d;

    logic                   sample;
    logic                   calib;
    logic                   ev_vld;
    logic                   ev_place;
    logic [5:0]             ev_sq;
    logic [5:0]             sq_c;
    logic [CW-1:0]          inc_c;

    assign sample = habilita && (set_q == SET_LAST);
    assign calib  = (state_q == CALIBRA);

    // Row scanning: each row is driven for SETTLE cycles, sampled on the last one.
    always_comb begin
        row_d = row_q;
        set_d = set_q;
        if (!habilita) begin
            row_d = 3'd0;
            set_d = '0;
        end else if (sample) begin
            set_d = '0;
            row_d = row_q + 3'd1;
        end else begin
            set_d = set_q + 1'b1;
        end
    end

    // Per-square debounce. Outside calibration only the lowest column that
    // reaches threshold flips; the rest saturate and win on a later sample.
    always_comb begin
        acc_d    = acc_q;
        dcnt_d   = dcnt_q;
        ev_vld   = 1'b0;
        ev_place = 1'b0;
        ev_sq    = 6'd0;
        sq_c     = 6'd0;
        inc_c    = '0;
        if (sample) begin
            for (int c = 0; c < 8; c++) begin
                sq_c = {row_q, 3'(c)};
                if (colunas[c] == acc_q[sq_c]) begin
                    dcnt_d[sq_c] = '0;
                end else begin
                    inc_c = (dcnt_q[sq_c] == DB_MAX) ? DB_MAX : dcnt_q[sq_c] + 1'b1;
                    if (inc_c == DB_MAX && (calib || !ev_vld)) begin
                        acc_d[sq_c]  = colunas[c];
                        dcnt_d[sq_c] = '0;
                        if (!calib) begin
                            ev_vld   = 1'b1;
                            ev_place = colunas[c];
                            ev_sq    = sq_c;
                        end
                    end else begin
                        dcnt_d[sq_c] = inc_c;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        org_d   = org_q;
        cap_d   = cap_q;
        scan_d  = scan_q;
        dest_d  = dest_q;
        orig_d  = orig_q;
        snap_d  = snap_q;
        jogou_d = 1'b0;
        if (!habilita) begin
            state_d = CALIBRA;
            scan_d  = '0;
        end else begin
            case (state_q)
                CALIBRA: begin
                    if (sample && row_q == 3'd7) begin
                        if (scan_q == DB_MAX - 1'b1) begin
                            state_d = OCIOSO;
                            scan_d  = '0;
                        end else begin
                            scan_d = scan_q + 1'b1;
                        end
                    end
                end
                OCIOSO: begin
                    if (ev_vld) begin
                        if (!ev_place) begin
                            org_d   = ev_sq;
                            state_d = LEVANTADA;
                        end else begin
                            state_d = ERRO;
                        end
                    end
                end
                LEVANTADA: begin
                    if (ev_vld) begin
                        if (!ev_place) begin
                            cap_d   = ev_sq;
                            state_d = CAPTURA;
                        end else begin
                            if (ev_sq != org_q) begin
                                jogou_d = 1'b1;
                                dest_d  = ev_sq;
                                orig_d  = org_q;
                            end
                            state_d = OCIOSO;
                        end
                    end
                end
                CAPTURA: begin
                    if (ev_vld) begin
                        if (ev_place && ev_sq == cap_q) begin
                            jogou_d = 1'b1;
                            dest_d  = ev_sq;
                            orig_d  = org_q;
                            state_d = OCIOSO;
                        end else begin
                            state_d = ERRO;
                        end
                    end
                end
                ERRO: begin
                    if (sample && row_q == 3'd7 && acc_d == snap_q)
                        state_d = OCIOSO;
                end
                default: state_d = CALIBRA;
            endcase
        end
        // Reference board for error recovery is the board as it stood on entry to idle.
        if (state_d == OCIOSO && state_q != OCIOSO)
            snap_d = acc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q   <= 3'd0;
            set_q   <= '0;
            acc_q   <= '0;
            dcnt_q  <= '0;
            snap_q  <= '0;
            state_q <= CALIBRA;
            org_q   <= 6'd0;
            cap_q   <= 6'd0;
            scan_q  <= '0;
            dest_q  <= 6'd0;
            orig_q  <= 6'd0;
            jogou_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            set_q   <= set_d;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            org_q   <= org_d;
            cap_q   <= cap_d;
            scan_q  <= scan_d;
            dest_q  <= dest_d;
            orig_q  <= orig_d;
            jogou_q <= jogou_d;
        end
    end

    assign linhas_varredura = (habilita && !reset) ? (8'b1 << row_q) : 8'b0;
    assign jogadaLinha      = {1'b0, dest_q[5:3]};
    assign jogadaColuna     = {1'b0, dest_q[2:0]};
    assign origemLinha      = {1'b0, orig_q[5:3]};
    assign origemColuna     = {1'b0, orig_q[2:0]};
    assign jogou            = jogou_q;
    assign erroMulti        = (state_q == ERRO);
    assign db_estado        = state_q;

endmodule
